status_rr_sched: RTL
====================

# status_rr_sched

Round-robin scheduler that shares the single downstream status port among NUM_REQ DDR channel FSMs. Each requester posts a one-cycle request with a packed status payload, and the block latches the request as pending. When the status consumer is idle, it grants one requester in fair rotation, captures that requester's payload and issues a one-cycle ack. It then waits for the consumer's busy/idle cycle to finish before it grants again. An optional watchdog recovers the scheduler if the consumer never takes the ack.

## Interface
Parameters:
- NUM_REQ, 6: number of requesters, range 2..16.
- PAYLOAD_W, 31: payload bits per requester, packed as {ack_type[1], VR_id[9], VR_FR[3], channel_ID[5], pos_1st[8], pos_2nd[3], src_type[2]}.
- TIMEOUT_CYC, 255: watchdog limit in cycles (1..65535); used only with the watchdog macro.

Ports:
- sys_clk, in, 1: single clock; all logic on the rising edge.
- sys_rst, in, 1: **synchronous, active-high reset.**
- req_i, in, NUM_REQ: request pulse per requester.
- req_payload_i, in, NUM_REQ*PAYLOAD_W: payloads; requester k uses slice [k*PAYLOAD_W +: PAYLOAD_W] and holds it stable from its request until its grant.
- grant_o, out, NUM_REQ: one-hot, one-cycle grant.
- status_idle_i, in, 1: consumer idle, high when it can accept.
- status_ack_o, out, 1: one-cycle ack toward the consumer.
- status_payload_o, out, PAYLOAD_W: payload of the last grant, held until the next grant.
- pending_o, out, NUM_REQ: latched pending requests.
- last_grant_o, out, 4: index of the most recently granted requester.
- timeout_o, out, 1: one-cycle watchdog pulse; tied to 0 when the watchdog is compiled out.

## Operation
- Pending latch k:
  - Set on req_i[k].
  - Cleared in the cycle grant_o[k] is high.
  - If req_i[k] arrives in the same cycle as grant_o[k], the set wins: the latch stays 1 and the new request is served later.
- FSM states: IDLE, GRANT, ACK, WAIT_BUSY, WAIT_IDLE.
  - IDLE: if status_idle_i=1 and |pending_o, select the winner and go to GRANT; otherwise stay.
  - GRANT: grant_o[winner]=1; capture the winner's payload slice into status_payload_o; set last_grant_o=winner; go to ACK.
  - ACK: status_ack_o=1; go to WAIT_BUSY.
  - WAIT_BUSY: stay while status_idle_i=1; on status_idle_i=0 go to WAIT_IDLE.
  - WAIT_IDLE: stay while status_idle_i=0; on status_idle_i=1 go to IDLE.
- Winner selection: the first set bit of pending_o, searching upward from last_grant_o+1 modulo NUM_REQ. The winner is registered on entry to GRANT.
- A pending requester waits at most NUM_REQ-1 other grants.
- Only one grant is outstanding at a time; no grant is issued in any state other than IDLE→GRANT.
- Reset, including reset in the middle of a transaction:
  - pending_o=0, grant_o=0, status_ack_o=0, status_payload_o=0, last_grant_o=NUM_REQ-1, timeout_o=0, state=IDLE.
  - An in-flight transaction is dropped without an ack.

## Timing
- req_i[k] at cycle t: pending_o[k]=1 at t+1.
- With the FSM in IDLE and status_idle_i=1 at t+1: grant_o[k]=1 at t+2, status_ack_o=1 and new status_payload_o at t+3.
- Earliest next grant: 2 cycles after status_idle_i returns high in WAIT_IDLE (one cycle to reach IDLE, one to reach GRANT).
- Back-to-back requesters therefore see grants at least 5 cycles apart.
- status_idle_i sampled low while in IDLE: no grant; pending requests are kept.

## Configuration
- Macro STATUS_RR_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and increments each cycle spent in WAIT_BUSY.
  - When the counter reaches TIMEOUT_CYC, timeout_o pulses for one cycle and the FSM returns to IDLE.
  - The timed-out grant counts as served; its pending bit stays cleared.
- Undefined: WAIT_BUSY waits indefinitely; timeout_o is constant 0; the counter is not built.

## Test plan
- Single request: status_idle_i=1, req_i=6'b000100 at t0 with payload slice 2 = 31'h1234ABC → grant_o=6'b000100 at t0+2; status_ack_o=1 and status_payload_o=31'h1234ABC at t0+3; last_grant_o=2.
- Round robin: req_i=6'b111111 in one cycle; consumer drops idle for 2 cycles after each ack → grant order 0,1,2,3,4,5; each grant is a single cycle.
- Fairness: after grant to requester 3, both 1 and 5 are pending → requester 5 is granted before requester 1.
- Simultaneous set/clear: req_i[0] repeated in the grant_o[0] cycle → pending_o[0] stays 1 and requester 0 is granted again in its next round-robin turn.
- Idle hold-off: status_idle_i=0 with pending_o=6'b000010 → no grant for 20 cycles; grant_o[1]=1 two cycles after idle rises.
- Watchdog (macro defined, TIMEOUT_CYC=8): status_idle_i held at 1 after an ack → timeout_o pulses 8 cycles after WAIT_BUSY entry; the next pending requester is granted afterwards.
- Reset mid-WAIT_IDLE: all outputs take their reset values the cycle after sys_rst, and pending is lost.

Source files
------------

// File: rtl/status_rr_sched.sv
// status_rr_sched: round-robin sharing of one status port among NUM_REQ DDR channel FSMs.
// Optional consumer watchdog is compiled in with `define STATUS_RR_WATCHDOG_EN.
module status_rr_sched #(
    parameter int NUM_REQ     = 6,
    parameter int PAYLOAD_W   = 31,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload_i,
    output logic [NUM_REQ-1:0]           grant_o,
    input  logic                         status_idle_i,
    output logic                         status_ack_o,
    output logic [PAYLOAD_W-1:0]         status_payload_o,
    output logic [NUM_REQ-1:0]           pending_o,
    output logic [3:0]                   last_grant_o,
    output logic                         timeout_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        ACK       = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] NONE       = {NUM_REQ{1'b0}};
    localparam logic [3:0]         LAST_RST   = 4'(NUM_REQ - 1);
    localparam logic [4:0]         NUM_REQ_W5 = 5'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("status_rr_sched: NUM_REQ must be within 2..16");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("status_rr_sched: TIMEOUT_CYC must be within 1..65535");
    end

    state_t                 state_r;
    state_t                 state_s;
    logic [NUM_REQ-1:0]     pending_r;
    logic [NUM_REQ-1:0]     grant_r;
    logic                   ack_r;
    logic                   timeout_r;
    logic [PAYLOAD_W-1:0]   payload_r;
    logic [3:0]             last_r;
    logic [3:0]             winner_r;
    logic [3:0]             pick_s;
    logic                   go_s;
    logic                   timeout_s;
    logic [PAYLOAD_W-1:0]   pay_arr_s [16];

    // Unused slots read as zero so a 4-bit winner index always selects a defined slice.
    for (genvar k = 0; k < 16; k++) begin : g_pay
        if (k < NUM_REQ) begin : g_used
            assign pay_arr_s[k] = req_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
        end else begin : g_unused
            assign pay_arr_s[k] = {PAYLOAD_W{1'b0}};
        end
    end

    // First pending requester found searching upward from last_r+1, wrapping at NUM_REQ.
    always_comb begin : p_pick
        logic [15:0] pend16_s;
        logic [4:0]  idx_s;
        logic        found_s;
        pend16_s = 16'(pending_r);
        pick_s   = last_r;
        found_s  = 1'b0;
        idx_s    = 5'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = {1'b0, last_r} + 5'(i);
            if (idx_s >= NUM_REQ_W5) begin
                idx_s = idx_s - NUM_REQ_W5;
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && pend16_s[idx_s[3:0]]) begin
                pick_s  = idx_s[3:0];
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

`ifdef STATUS_RR_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
    logic [15:0] wd_cnt_r;

    // Watchdog: cycles spent in WAIT_BUSY, cleared while the ack is issued.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r == ACK) begin
            wd_cnt_r <= 16'd0;
        end else if (state_r == WAIT_BUSY) begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`endif

    // Next-state logic of the grant/ack/handshake sequence.
    always_comb begin
        state_s   = state_r;
        go_s      = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (status_idle_i && (pending_r != NONE)) begin
                    state_s = GRANT;
                    go_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT:     state_s = ACK;
            ACK:       state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!status_idle_i) begin
                    state_s = WAIT_IDLE;
`ifdef STATUS_RR_WATCHDOG_EN
                end else if (wd_cnt_r + 16'd1 == TIMEOUT_LIM) begin
                    state_s   = IDLE;
                    timeout_s = 1'b1;
`endif
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_IDLE: begin
                if (status_idle_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            default:   state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs; a request coinciding with its own grant keeps the pending bit set.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending_r <= NONE;
            grant_r   <= NONE;
            winner_r  <= LAST_RST;
            ack_r     <= 1'b0;
            timeout_r <= 1'b0;
            payload_r <= {PAYLOAD_W{1'b0}};
            last_r    <= LAST_RST;
        end else begin
            pending_r <= (pending_r & ~grant_r) | req_i;
            grant_r   <= go_s ? (ONE_HOT0 << pick_s) : NONE;
            winner_r  <= go_s ? pick_s : winner_r;
            ack_r     <= (state_r == GRANT);
            timeout_r <= timeout_s;
            if (state_r == GRANT) begin
                payload_r <= pay_arr_s[winner_r];
                last_r    <= winner_r;
            end else begin
                payload_r <= payload_r;
                last_r    <= last_r;
            end
        end
    end

    assign grant_o          = grant_r;
    assign status_ack_o     = ack_r;
    assign status_payload_o = payload_r;
    assign pending_o        = pending_r;
    assign last_grant_o     = last_r;
    assign timeout_o        = timeout_r;

endmodule
